// File: rtl/sc_spi_pkg.sv
// Shared definitions for the SPI engine blocks: buffer geometry, word and
// width-code sizes, and the buffer controller state encoding.
package sc_spi_pkg;

    localparam int PTR_W     = 4;
    localparam int WORD_W    = 32;
    localparam int DW_W      = 9;
    localparam int BUF_DEPTH = 16;
    localparam int RXCNT_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WBSY  = 3'd2,
        ST_WEND  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_FIN   = 3'd5
    } bfc_state_t;

endpackage

// File: rtl/sc_spi_bfc_ram.sv
// 16x32 register file: one write port, one registered read port and one
// combinational read port. Contents are never reset.
module sc_spi_bfc_ram
    import sc_spi_pkg::*;
(
    input  logic              SPICLK,
    input  logic              SYSRSTB,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [WORD_W-1:0] rdata,
    input  logic [PTR_W-1:0]  aaddr,
    output logic [WORD_W-1:0] adata
);

    logic [WORD_W-1:0] mem [BUF_DEPTH];
    logic [WORD_W-1:0] rdata_reg;

    always_ff @(posedge SPICLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A write and a read of the same word in one cycle return the old word.
    always_ff @(posedge SPICLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            rdata_reg <= '0;
        end else begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;
    assign adata = mem[aaddr];

endmodule

// File: rtl/sc_spi_bfc.sv
// SPI buffer controller: TX/RX word buffers plus the command sequencer in
// front of the SPI protocol engine. Optional busy timeout: SC_SPI_BFC_TIMEOUT_EN.
module sc_spi_bfc
    import sc_spi_pkg::*;
#(
    parameter int DRAIN_CYC = 3,
    parameter int TO_W      = 16
) (
    input  logic               SPICLK,
    input  logic               SYSRSTB,
    input  logic               TXWE,
    input  logic [PTR_W-1:0]   TXWADDR,
    input  logic [WORD_W-1:0]  TXWDATA,
    input  logic [PTR_W-1:0]   RXRADDR,
    output logic [WORD_W-1:0]  RXRDATA,
    input  logic               CMDVALID,
    output logic               CMDREADY,
    input  logic [DW_W-1:0]    CMDDW,
    input  logic               CMDCSEXT,
    output logic               DONE,
    output logic [RXCNT_W-1:0] RXCNT,
    output logic               TIMEOUT,
    output logic               SPISTART,
    input  logic               SPIBUSY,
    output logic [DW_W-1:0]    DWIDTH,
    output logic               CSEXTEND,
    output logic [WORD_W-1:0]  TXDATA,
    input  logic [PTR_W-1:0]   TXDPT,
    input  logic [WORD_W-1:0]  RXDATA,
    input  logic               RXVALID,
    input  logic [PTR_W-1:0]   RXDPT
);

    localparam int                 DRN_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DRN_W-1:0]   DRN_LOAD = DRN_W'(DRAIN_CYC - 1);
    localparam logic [RXCNT_W-1:0] RXCNT_MAX = RXCNT_W'(BUF_DEPTH);

    if (DRAIN_CYC < 1 || TO_W < 2) begin : g_param_chk
        $error("sc_spi_bfc: DRAIN_CYC must be >= 1 and TO_W >= 2");
    end

    bfc_state_t         state_reg, state_next;
    logic [DRN_W-1:0]   drain_reg, drain_next;
    logic [DW_W-1:0]    dwidth_reg;
    logic               csext_reg;
    logic [RXCNT_W-1:0] rxcnt_reg;
    logic               cmd_accept;
    logic               to_fire;
    logic [WORD_W-1:0]  unused_tx_rdata;
    logic [WORD_W-1:0]  unused_rx_adata;

    always_ff @(posedge SPICLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            state_reg <= ST_IDLE;
            drain_reg <= '0;
        end else begin
            state_reg <= state_next;
            drain_reg <= drain_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        drain_next = drain_reg;
        cmd_accept = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (CMDVALID) begin
                    cmd_accept = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: state_next = ST_WBSY;
            ST_WBSY: begin
                if (SPIBUSY) begin
                    state_next = ST_WEND;
                end else if (to_fire) begin
                    state_next = ST_FIN;
                end
            end
            ST_WEND: begin
                if (!SPIBUSY) begin
                    drain_next = DRN_LOAD;
                    state_next = ST_DRAIN;
                end else if (to_fire) begin
                    state_next = ST_FIN;
                end
            end
            // Covers RX words still in flight in the engine after busy drops.
            ST_DRAIN: begin
                if (drain_reg == '0) begin
                    state_next = ST_FIN;
                end else begin
                    drain_next = drain_reg - 1'b1;
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign CMDREADY = (state_reg == ST_IDLE);
    assign SPISTART = (state_reg == ST_START);
    assign DONE     = (state_reg == ST_FIN);

    always_ff @(posedge SPICLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            dwidth_reg <= '0;
            csext_reg  <= 1'b0;
        end else if (cmd_accept) begin
            dwidth_reg <= CMDDW;
            csext_reg  <= CMDCSEXT;
        end
    end

    // Words landing while idle still go to the buffer but are not counted.
    always_ff @(posedge SPICLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            rxcnt_reg <= '0;
        end else if (cmd_accept) begin
            rxcnt_reg <= '0;
        end else if (RXVALID && state_reg != ST_IDLE && rxcnt_reg != RXCNT_MAX) begin
            rxcnt_reg <= rxcnt_reg + 1'b1;
        end
    end

    assign DWIDTH   = dwidth_reg;
    assign CSEXTEND = csext_reg;
    assign RXCNT    = rxcnt_reg;

`ifdef SC_SPI_BFC_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_reg;
    logic            timeout_reg;

    // Counts every cycle spent waiting on the engine; the engine is left running on expiry.
    always_ff @(posedge SPICLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            to_cnt_reg <= '0;
        end else if (state_reg == ST_START) begin
            to_cnt_reg <= '0;
        end else if (state_reg == ST_WBSY || state_reg == ST_WEND) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
        end
    end

    assign to_fire = (&to_cnt_reg) &&
                     ((state_reg == ST_WBSY && !SPIBUSY) ||
                      (state_reg == ST_WEND &&  SPIBUSY));

    always_ff @(posedge SPICLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            timeout_reg <= 1'b0;
        end else if (cmd_accept) begin
            timeout_reg <= 1'b0;
        end else if (to_fire) begin
            timeout_reg <= 1'b1;
        end
    end

    assign TIMEOUT = timeout_reg;
`else
    assign to_fire = 1'b0;
    assign TIMEOUT = 1'b0;
`endif

    sc_spi_bfc_ram u_txbuf (
        .SPICLK  (SPICLK),
        .SYSRSTB (SYSRSTB),
        .we      (TXWE),
        .waddr   (TXWADDR),
        .wdata   (TXWDATA),
        .raddr   ('0),
        .rdata   (unused_tx_rdata),
        .aaddr   (TXDPT),
        .adata   (TXDATA)
    );

    sc_spi_bfc_ram u_rxbuf (
        .SPICLK  (SPICLK),
        .SYSRSTB (SYSRSTB),
        .we      (RXVALID),
        .waddr   (RXDPT),
        .wdata   (RXDATA),
        .raddr   (RXRADDR),
        .rdata   (RXRDATA),
        .aaddr   ('0),
        .adata   (unused_rx_adata)
    );

endmodule

// File: tb/tb_sc_spi_bfc.sv
// Directed bench for sc_spi_bfc with a hand-driven engine model; the timeout
// section is built only when SC_SPI_BFC_TIMEOUT_EN is defined.
module tb_sc_spi_bfc;
    import sc_spi_pkg::*;

    logic               SPICLK;
    logic               SYSRSTB;
    logic               TXWE;
    logic [PTR_W-1:0]   TXWADDR;
    logic [WORD_W-1:0]  TXWDATA;
    logic [PTR_W-1:0]   RXRADDR;
    logic [WORD_W-1:0]  RXRDATA;
    logic               CMDVALID;
    logic               CMDREADY;
    logic [DW_W-1:0]    CMDDW;
    logic               CMDCSEXT;
    logic               DONE;
    logic [RXCNT_W-1:0] RXCNT;
    logic               TIMEOUT;
    logic               SPISTART;
    logic               SPIBUSY;
    logic [DW_W-1:0]    DWIDTH;
    logic               CSEXTEND;
    logic [WORD_W-1:0]  TXDATA;
    logic [PTR_W-1:0]   TXDPT;
    logic [WORD_W-1:0]  RXDATA;
    logic               RXVALID;
    logic [PTR_W-1:0]   RXDPT;

    sc_spi_bfc #(.DRAIN_CYC(3), .TO_W(4)) dut (
        .SPICLK   (SPICLK),
        .SYSRSTB  (SYSRSTB),
        .TXWE     (TXWE),
        .TXWADDR  (TXWADDR),
        .TXWDATA  (TXWDATA),
        .RXRADDR  (RXRADDR),
        .RXRDATA  (RXRDATA),
        .CMDVALID (CMDVALID),
        .CMDREADY (CMDREADY),
        .CMDDW    (CMDDW),
        .CMDCSEXT (CMDCSEXT),
        .DONE     (DONE),
        .RXCNT    (RXCNT),
        .TIMEOUT  (TIMEOUT),
        .SPISTART (SPISTART),
        .SPIBUSY  (SPIBUSY),
        .DWIDTH   (DWIDTH),
        .CSEXTEND (CSEXTEND),
        .TXDATA   (TXDATA),
        .TXDPT    (TXDPT),
        .RXDATA   (RXDATA),
        .RXVALID  (RXVALID),
        .RXDPT    (RXDPT)
    );

    initial SPICLK = 1'b0;
    always #5 SPICLK = ~SPICLK;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int done_cnt = 0;

    always @(posedge SPICLK) begin
        if (SPISTART) start_cnt <= start_cnt + 1;
        if (DONE)     done_cnt  <= done_cnt + 1;
    end

    typedef struct {
        logic [PTR_W-1:0]  addr;
        logic [WORD_W-1:0] data;
    } buf_vec_t;

    buf_vec_t tx_tab[6];
    buf_vec_t rx_tab[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge SPICLK);
        #1;
    endtask

    task automatic issue_cmd(input logic [DW_W-1:0] dw, input logic cs);
        CMDDW    = dw;
        CMDCSEXT = cs;
        CMDVALID = 1'b1;
        tick();
        CMDVALID = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int n = 0;
        while (!DONE && n < 40) begin
            tick();
            n++;
        end
        chk(name, n, exp_lat);
    endtask

    initial begin
        int s0, d0;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0;
        tx_tab[0] = '{4'd0,  32'hA5A5_0001};
        tx_tab[1] = '{4'd1,  32'h5A5A_0002};
        tx_tab[2] = '{4'd7,  32'h0000_0077};
        tx_tab[3] = '{4'd15, 32'hFFFF_000F};
        tx_tab[4] = '{4'd8,  32'h8000_0008};
        tx_tab[5] = '{4'd3,  32'h3333_3333};
        rx_tab[0] = '{4'd0,  32'h0BAD_0000};
        rx_tab[1] = '{4'd15, 32'hF00D_000F};
        rx_tab[2] = '{4'd3,  32'h1234_5678};
        rx_tab[3] = '{4'd9,  32'h9999_0009};
        rx_tab[4] = '{4'd6,  32'h6666_6666};

        SYSRSTB = 1'b0; TXWE = 1'b0; TXWADDR = '0; TXWDATA = '0;
        RXRADDR = '0; CMDVALID = 1'b0; CMDDW = '0; CMDCSEXT = 1'b0;
        SPIBUSY = 1'b0; TXDPT = '0; RXDATA = '0; RXVALID = 1'b0; RXDPT = '0;
        #1;
        chk("rst_cmdready", CMDREADY, 1);
        chk("rst_spistart", SPISTART, 0);
        chk("rst_done", DONE, 0);
        chk("rst_rxcnt", RXCNT, 0);
        chk("rst_dwidth", DWIDTH, 0);
        chk("rst_csextend", CSEXTEND, 0);
        chk("rst_rxrdata", RXRDATA, 0);
        chk("rst_timeout", TIMEOUT, 0);
        tick(); tick();
        SYSRSTB = 1'b1;
        tick();

        // TX buffer table: write all, then read back through TXDPT
        foreach (tx_tab[i]) begin
            TXWE = 1'b1; TXWADDR = tx_tab[i].addr; TXWDATA = tx_tab[i].data;
            tick();
        end
        TXWE = 1'b0;
        foreach (tx_tab[i]) begin
            TXDPT = tx_tab[i].addr;
            #1;
            chk($sformatf("txdata_tab%0d", i), TXDATA, tx_tab[i].data);
        end
        $display("xfer tx table: %0d words", $size(tx_tab));

        // RX buffer table: captures while idle, read back with 1-cycle latency
        foreach (rx_tab[i]) begin
            RXVALID = 1'b1; RXDPT = rx_tab[i].addr; RXDATA = rx_tab[i].data;
            tick();
        end
        RXVALID = 1'b0;
        chk("idle_rx_no_count", RXCNT, 0);
        foreach (rx_tab[i]) begin
            RXRADDR = rx_tab[i].addr;
            tick();
            chk($sformatf("rxrdata_tab%0d", i), RXRDATA, rx_tab[i].data);
        end
        $display("xfer rx table: %0d words", $size(rx_tab));

        // Same-cycle capture and read of one word: old data first, new next
        RXRADDR = 4'd3; RXVALID = 1'b1; RXDPT = 4'd3; RXDATA = 32'hCAFE_0003;
        tick();
        RXVALID = 1'b0;
        chk("rd_wr_collide_old", RXRDATA, 32'h1234_5678);
        tick();
        chk("rd_wr_collide_new", RXRDATA, 32'hCAFE_0003);

        // Basic 64-bit transfer with two RX words
        s0 = start_cnt; d0 = done_cnt;
        issue_cmd(9'd63, 1'b1);
        chk("x1_spistart", SPISTART, 1);
        chk("x1_cmdready", CMDREADY, 0);
        chk("x1_dwidth", DWIDTH, 63);
        chk("x1_csextend", CSEXTEND, 1);
        tick();
        chk("x1_spistart_1cyc", SPISTART, 0);
        SPIBUSY = 1'b1; TXDPT = 4'd1;
        #1;
        chk("x1_txdata_ptr1", TXDATA, 32'h5A5A_0002);
        tick();
        TXDPT = 4'd0;
        #1;
        chk("x1_txdata_ptr0", TXDATA, 32'hA5A5_0001);
        RXVALID = 1'b1; RXDPT = 4'd0; RXDATA = 32'h1111_0000;
        tick();
        RXDPT = 4'd1; RXDATA = 32'h2222_0001;
        tick();
        RXVALID = 1'b0; SPIBUSY = 1'b0;
        tick();
        chk("x1_rxcnt", RXCNT, 2);
        wait_done("x1_done_lat", 3);
        tick();
        chk("x1_done_pulse", DONE, 0);
        chk("x1_cmdready_back", CMDREADY, 1);
        chk("x1_start_count", start_cnt - s0, 1);
        chk("x1_done_count", done_cnt - d0, 1);
        RXRADDR = 4'd1;
        tick();
        chk("x1_rxword1", RXRDATA, 32'h2222_0001);
        RXRADDR = 4'd0;
        tick();
        chk("x1_rxword0", RXRDATA, 32'h1111_0000);
        $display("xfer basic dw=63 rxcnt=%0d", RXCNT);

        // CMDVALID held through the transfer is not queued
        s0 = start_cnt; d0 = done_cnt;
        CMDDW = 9'd31; CMDCSEXT = 1'b0; CMDVALID = 1'b1;
        tick();
        tick();
        SPIBUSY = 1'b1;
        tick();
        chk("x2_cmdready_wend", CMDREADY, 0);
        tick();
        chk("x2_no_restart", SPISTART, 0);
        SPIBUSY = 1'b0;
        tick();
        wait_done("x2_done_lat", 3);
        CMDVALID = 1'b0;
        tick();
        tick();
        chk("x2_start_count", start_cnt - s0, 1);
        chk("x2_done_count", done_cnt - d0, 1);
        $display("xfer held cmdvalid dw=31");

        // Late RX word two cycles after busy falls, 16-word width code
        issue_cmd(9'd511, 1'b0);
        chk("x3_dwidth_max", DWIDTH, 511);
        tick();
        SPIBUSY = 1'b1;
        tick();
        SPIBUSY = 1'b0;
        tick();
        tick();
        RXVALID = 1'b1; RXDPT = 4'd5; RXDATA = 32'hC0FF_EE05;
        tick();
        RXVALID = 1'b0;
        chk("x3_late_rxcnt", RXCNT, 1);
        chk("x3_no_early_done", DONE, 0);
        tick();
        chk("x3_done_after_capture", DONE, 1);
        tick();
        RXRADDR = 4'd5;
        tick();
        chk("x3_late_word", RXRDATA, 32'hC0FF_EE05);
        $display("xfer late rx dw=511");

        // RXCNT saturates at 16 after 17 strobes
        issue_cmd(9'd511, 1'b0);
        tick();
        SPIBUSY = 1'b1;
        tick();
        RXVALID = 1'b1;
        for (int i = 0; i < 17; i++) begin
            RXDPT = 4'(i); RXDATA = 32'(i);
            tick();
        end
        RXVALID = 1'b0;
        chk("x4_rxcnt_sat", RXCNT, 16);
        SPIBUSY = 1'b0;
        tick();
        wait_done("x4_done_lat", 3);
        tick();
        $display("xfer saturation rxcnt=%0d", RXCNT);

        // Asynchronous reset in WEND, then a 1-bit transfer
        issue_cmd(9'd100, 1'b1);
        tick();
        SPIBUSY = 1'b1;
        tick();
        RXVALID = 1'b1; RXDPT = 4'd2; RXDATA = 32'h2020_2020; RXRADDR = 4'd2;
        tick();
        RXVALID = 1'b0;
        tick();
        chk("x5_pre_rst_rxrdata", RXRDATA, 32'h2020_2020);
        #2;
        SYSRSTB = 1'b0;
        #1;
        chk("x5_rst_cmdready", CMDREADY, 1);
        chk("x5_rst_spistart", SPISTART, 0);
        chk("x5_rst_done", DONE, 0);
        chk("x5_rst_rxcnt", RXCNT, 0);
        chk("x5_rst_dwidth", DWIDTH, 0);
        chk("x5_rst_csextend", CSEXTEND, 0);
        chk("x5_rst_rxrdata", RXRDATA, 0);
        SPIBUSY = 1'b0;
        tick();
        SYSRSTB = 1'b1;
        tick();
        s0 = start_cnt; d0 = done_cnt;
        issue_cmd(9'd0, 1'b1);
        chk("x5_restart", SPISTART, 1);
        chk("x5_csextend", CSEXTEND, 1);
        tick();
        SPIBUSY = 1'b1;
        tick();
        SPIBUSY = 1'b0;
        tick();
        wait_done("x5_done_lat", 3);
        tick();
        chk("x5_done_count", done_cnt - d0, 1);
        $display("xfer after reset dw=0");

`ifdef SC_SPI_BFC_TIMEOUT_EN
        // Busy stuck high: timeout after 16 waiting cycles
        issue_cmd(9'd15, 1'b0);
        SPIBUSY = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        chk("to_not_yet", DONE, 0);
        tick();
        chk("to_done", DONE, 1);
        chk("to_flag", TIMEOUT, 1);
        tick();
        chk("to_idle", CMDREADY, 1);
        chk("to_sticky", TIMEOUT, 1);
        SPIBUSY = 1'b0;
        issue_cmd(9'd15, 1'b0);
        chk("to_cleared", TIMEOUT, 0);
        tick();
        SPIBUSY = 1'b1;
        tick();
        SPIBUSY = 1'b0;
        tick();
        wait_done("to_next_done_lat", 3);
        tick();
        $display("xfer timeout");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
